// File: rtl/simd_pkg.sv
// simd_pkg: shared state type and default parameters for the 3x3 matrix-multiply sequencer
package simd_pkg;
    typedef enum logic [2:0] {IDLE, ISSUE, ACC, WRITE, DONE} state_t;
    localparam int DW_DEF     = 8;
    localparam int AW_DEF     = 4;
    localparam int A_BASE_DEF = 0;
    localparam int B_BASE_DEF = 3;
    localparam int C_BASE_DEF = 6;
    localparam int ACC_GUARD  = 2;
    localparam int ACC_W_DEF  = 2 * DW_DEF + ACC_GUARD;
endpackage

// File: rtl/simd_mac3.sv
// simd_mac3: three unsigned DW x DW multiply-accumulate lanes sharing one A operand
// Macro SIMD_MM_SAT_EN: lane outputs saturate to 2^DW-1 instead of truncating.
module simd_mac3 import simd_pkg::*; #(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b0,
    input  logic [DW-1:0] b1,
    input  logic [DW-1:0] b2,
    output logic [DW-1:0] y0,
    output logic [DW-1:0] y1,
    output logic [DW-1:0] y2
);
    localparam int ACW = 2 * DW + ACC_GUARD;

    logic [2:0][DW-1:0] w_b;
    logic [2:0][DW-1:0] w_y;

    assign w_b = {b2, b1, b0};
    assign y0  = w_y[0];
    assign y1  = w_y[1];
    assign y2  = w_y[2];

    for (genvar j = 0; j < 3; j++) begin : g_lane
        logic [2*DW-1:0] w_p;
        logic [ACW-1:0]  r_acc;
        assign w_p = (2*DW)'(a) * (2*DW)'(w_b[j]);
        // Accumulator: clear has priority so a new row never inherits old sums
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) r_acc <= '0;
            else if (clr) r_acc <= '0;
            else if (en) r_acc <= r_acc + ACW'(w_p);
`ifdef SIMD_MM_SAT_EN
        assign w_y[j] = |r_acc[ACW-1:DW] ? {DW{1'b1}} : r_acc[DW-1:0];
`else
        assign w_y[j] = r_acc[DW-1:0];
`endif
    end
endmodule

// File: rtl/simd_mm_seq.sv
// simd_mm_seq: sequences C = A x B over a 3-bank register file, one row of C per 7 cycles
// Macro SIMD_MM_SAT_EN (in simd_mac3): saturating instead of truncating result conversion.
module simd_mm_seq import simd_pkg::*; #(
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF,
    parameter int A_BASE = A_BASE_DEF,
    parameter int B_BASE = B_BASE_DEF,
    parameter int C_BASE = C_BASE_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic          host_we,
    input  logic [AW-1:0] host_waddr,
    input  logic [DW-1:0] host_wdata0,
    input  logic [DW-1:0] host_wdata1,
    input  logic [DW-1:0] host_wdata2,
    output logic          host_ready,
    output logic          host_drop,
    output logic          rf_en_write,
    output logic [AW-1:0] rf_waddr1,
    output logic [AW-1:0] rf_waddr2,
    output logic [AW-1:0] rf_waddr3,
    output logic [DW-1:0] rf_wdata1,
    output logic [DW-1:0] rf_wdata2,
    output logic [DW-1:0] rf_wdata3,
    output logic          rf_en_read,
    output logic [AW-1:0] rf_raddr1,
    output logic [AW-1:0] rf_raddr2,
    output logic [AW-1:0] rf_raddr3,
    output logic [AW-1:0] rf_raddr4,
    output logic [AW-1:0] rf_raddr5,
    output logic [AW-1:0] rf_raddr6,
    input  logic [DW-1:0] rf_rdata1,
    input  logic [DW-1:0] rf_rdata2,
    input  logic [DW-1:0] rf_rdata3,
    input  logic [DW-1:0] rf_rdata4,
    input  logic [DW-1:0] rf_rdata5,
    input  logic [DW-1:0] rf_rdata6
);
    state_t        r_state, w_next;
    logic [1:0]    r_i, r_k;
    logic          r_drop;
    logic          w_idle, w_issue, w_write, w_host, w_start_ok;
    logic [DW-1:0] w_a, w_y0, w_y1, w_y2;
    logic [AW-1:0] w_ra, w_rb, w_wa;

    assign w_idle     = r_state == IDLE;
    assign w_issue    = r_state == ISSUE;
    assign w_write    = r_state == WRITE;
    assign w_host     = w_idle && host_we;
    assign w_start_ok = w_idle && start;
    assign w_a  = r_k == 2'd0 ? rf_rdata1 : r_k == 2'd1 ? rf_rdata2 : rf_rdata3;
    assign w_ra = w_issue ? AW'(A_BASE) + AW'(r_i) : '0;
    assign w_rb = w_issue ? AW'(B_BASE) + AW'(r_k) : '0;
    assign w_wa = w_write ? AW'(C_BASE) + AW'(r_i) : w_host ? host_waddr : '0;

    assign busy        = !w_idle;
    assign done        = r_state == DONE;
    assign host_ready  = w_idle;
    assign host_drop   = r_drop;
    assign rf_en_read  = w_issue;
    assign rf_en_write = w_write || w_host;
    assign rf_raddr1   = w_ra;
    assign rf_raddr2   = w_ra;
    assign rf_raddr3   = w_ra;
    assign rf_raddr4   = w_rb;
    assign rf_raddr5   = w_rb;
    assign rf_raddr6   = w_rb;
    assign rf_waddr1   = w_wa;
    assign rf_waddr2   = w_wa;
    assign rf_waddr3   = w_wa;
    assign rf_wdata1   = w_write ? w_y0 : w_host ? host_wdata0 : '0;
    assign rf_wdata2   = w_write ? w_y1 : w_host ? host_wdata1 : '0;
    assign rf_wdata3   = w_write ? w_y2 : w_host ? host_wdata2 : '0;

    // Next state: one ISSUE/ACC pair per k, a WRITE per row, DONE after row 2
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? ISSUE : IDLE;
            ISSUE:   w_next = ACC;
            ACC:     w_next = r_k == 2'd2 ? WRITE : ISSUE;
            WRITE:   w_next = r_i == 2'd2 ? DONE : ISSUE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State and row/column indices
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state <= IDLE;
            r_i     <= '0;
            r_k     <= '0;
        end else begin
            r_state <= w_next;
            if (w_start_ok) begin
                r_i <= '0;
                r_k <= '0;
            end else if (r_state == ACC && r_k != 2'd2) begin
                r_k <= r_k + 2'd1;
            end else if (w_write) begin
                r_i <= r_i == 2'd2 ? 2'd0 : r_i + 2'd1;
                r_k <= '0;
            end
        end

    // Sticky flag for host writes lost while the sequence owns the write port
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_drop <= 1'b0;
        else if (w_start_ok) r_drop <= 1'b0;
        else if (host_we && !w_idle) r_drop <= 1'b1;

    simd_mac3 #(.DW(DW)) u_mac (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (w_start_ok || w_write),
        .en   (r_state == ACC),
        .a    (w_a),
        .b0   (rf_rdata4),
        .b1   (rf_rdata5),
        .b2   (rf_rdata6),
        .y0   (w_y0),
        .y1   (w_y1),
        .y2   (w_y2)
    );
endmodule

// File: tb/tb_simd_mm_seq.sv
// tb_simd_mm_seq: directed bench with a register-file environment and a cycle-level reference model
module tb_simd_mm_seq;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int AB = 0;
    localparam int BB = 3;
    localparam int CB = 6;
`ifdef SIMD_MM_SAT_EN
    localparam int C_ALL = 255;
`else
    localparam int C_ALL = 3;
`endif

    logic clk = 0, rst_n = 0, start = 0, host_we = 0;
    logic [AW-1:0] host_waddr = '0;
    logic [DW-1:0] host_wdata0 = '0, host_wdata1 = '0, host_wdata2 = '0;
    logic busy, done, host_ready, host_drop, rf_en_write, rf_en_read;
    logic [AW-1:0] rf_waddr1, rf_waddr2, rf_waddr3;
    logic [DW-1:0] rf_wdata1, rf_wdata2, rf_wdata3;
    logic [AW-1:0] rf_raddr1, rf_raddr2, rf_raddr3, rf_raddr4, rf_raddr5, rf_raddr6;
    logic [DW-1:0] rf_rdata1, rf_rdata2, rf_rdata3, rf_rdata4, rf_rdata5, rf_rdata6;

    logic [DW-1:0] mem [3][16];
    int n_cmp = 0, n_bad = 0;
    int phase;
    logic exp_drop;
    logic prev_done = 0;
    int unsigned exp_c [3][3];

    always #5 clk = ~clk;

    simd_mm_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .host_we(host_we), .host_waddr(host_waddr),
        .host_wdata0(host_wdata0), .host_wdata1(host_wdata1), .host_wdata2(host_wdata2),
        .host_ready(host_ready), .host_drop(host_drop),
        .rf_en_write(rf_en_write), .rf_waddr1(rf_waddr1), .rf_waddr2(rf_waddr2), .rf_waddr3(rf_waddr3),
        .rf_wdata1(rf_wdata1), .rf_wdata2(rf_wdata2), .rf_wdata3(rf_wdata3),
        .rf_en_read(rf_en_read), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_raddr3(rf_raddr3),
        .rf_raddr4(rf_raddr4), .rf_raddr5(rf_raddr5), .rf_raddr6(rf_raddr6),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .rf_rdata3(rf_rdata3),
        .rf_rdata4(rf_rdata4), .rf_rdata5(rf_rdata5), .rf_rdata6(rf_rdata6)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int conv(input int unsigned a);
`ifdef SIMD_MM_SAT_EN
        return a > 255 ? 255 : int'(a);
`else
        return int'(a % 256);
`endif
    endfunction

    // Register file environment: three banks, registered read data
    always @(posedge clk) begin
        if (rf_en_write) begin
            mem[0][rf_waddr1] <= rf_wdata1;
            mem[1][rf_waddr2] <= rf_wdata2;
            mem[2][rf_waddr3] <= rf_wdata3;
        end
        if (rf_en_read) begin
            rf_rdata1 <= mem[0][rf_raddr1];
            rf_rdata2 <= mem[1][rf_raddr2];
            rf_rdata3 <= mem[2][rf_raddr3];
            rf_rdata4 <= mem[0][rf_raddr4];
            rf_rdata5 <= mem[1][rf_raddr5];
            rf_rdata6 <= mem[2][rf_raddr6];
        end
    end

    // Reference model: phase counts cycles since the accepted start (0 = idle)
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            phase    <= 0;
            exp_drop <= 0;
        end else begin
            if (phase == 0) phase <= start ? 1 : 0;
            else phase <= phase == 22 ? 0 : phase + 1;
            if (phase == 0 && start) exp_drop <= 0;
            else if (phase != 0 && host_we) exp_drop <= 1;
        end

    // Compare process: every cycle out of reset, outputs checked against the model
    always @(negedge clk) if (rst_n) begin : cmp
        int r, q;
        bit ir, iw, run;
        run = phase >= 1 && phase <= 21;
        r = run ? (phase - 1) / 7 : 0;
        q = run ? (phase - 1) % 7 : 0;
        if (phase == 1)
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) begin
                    exp_c[i][j] = 0;
                    for (int k = 0; k < 3; k++)
                        exp_c[i][j] += int'(mem[k][AB+i]) * int'(mem[j][BB+k]);
                end
        ir = run && (q == 0 || q == 2 || q == 4);
        iw = (run && q == 6) || (phase == 0 && host_we);
        chk("busy", busy, phase != 0);
        chk("done", done, phase == 22);
        chk("host_ready", host_ready, phase == 0);
        chk("host_drop", host_drop, exp_drop);
        chk("rf_en_read", rf_en_read, ir);
        chk("rf_en_write", rf_en_write, iw);
        chk("rd_wr_overlap", rf_en_read & rf_en_write, 0);
        chk("done_width", done & prev_done, 0);
        prev_done = done;
        if (ir) begin
            chk("raddr1", rf_raddr1, AB + r);
            chk("raddr2", rf_raddr2, AB + r);
            chk("raddr3", rf_raddr3, AB + r);
            chk("raddr4", rf_raddr4, BB + q / 2);
            chk("raddr5", rf_raddr5, BB + q / 2);
            chk("raddr6", rf_raddr6, BB + q / 2);
        end
        if (run && q == 6) begin
            chk("c_waddr", rf_waddr1, CB + r);
            chk("c_waddr3", rf_waddr3, CB + r);
            chk("c_wdata1", rf_wdata1, conv(exp_c[r][0]));
            chk("c_wdata2", rf_wdata2, conv(exp_c[r][1]));
            chk("c_wdata3", rf_wdata3, conv(exp_c[r][2]));
        end
        if (phase == 0 && host_we) begin
            chk("host_waddr_fwd", rf_waddr2, host_waddr);
            chk("host_wdata_fwd", rf_wdata1, host_wdata0);
            chk("host_wdata3_fwd", rf_wdata3, host_wdata2);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic hw(input int a, input int d0, input int d1, input int d2, input bit st);
        host_we = 1; host_waddr = AW'(a);
        host_wdata0 = DW'(d0); host_wdata1 = DW'(d1); host_wdata2 = DW'(d2);
        start = st;
        tick;
        host_we = 0; start = 0;
    endtask

    task automatic wait_done(input int c0, input int restart_at, output int cyc);
        cyc = c0;
        while (!done && cyc < 60) begin
            start = cyc == restart_at;
            tick;
            start = 0;
            cyc++;
        end
    endtask

    task automatic chk_row(input string nm, input int a, input int e0, input int e1, input int e2);
        chk({nm, "_b0"}, mem[0][a], e0);
        chk({nm, "_b1"}, mem[1][a], e1);
        chk({nm, "_b2"}, mem[2][a], e2);
    endtask

    initial begin
        int cyc;
        repeat (2) tick;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_en_read", rf_en_read, 0);
        chk("rst_en_write", rf_en_write, 0);
        chk("rst_drop", host_drop, 0);
        chk("rst_ready", host_ready, 1);
        chk("rst_waddr", rf_waddr1, 0);
        chk("rst_raddr", rf_raddr4, 0);
        rst_n = 1;
        tick;

        // A = [1,2,3;0,1,0;0,0,1], B = I, host write dropped during ISSUE
        hw(0, 1, 2, 3, 0); hw(1, 0, 1, 0, 0); hw(2, 0, 0, 1, 0);
        hw(3, 1, 0, 0, 0); hw(4, 0, 1, 0, 0); hw(5, 0, 0, 1, 0);
        start = 1; tick; start = 0;
        hw(CB, 99, 99, 99, 0);
        wait_done(2, -1, cyc);
        chk("t1_done_cycle", cyc, 22);
        tick;
        chk("t1_drop_sticky", host_drop, 1);
        chk("t1_idle", busy, 0);
        chk_row("t1_c0", CB, 1, 2, 3);
        chk_row("t1_c1", CB + 1, 0, 1, 0);
        chk_row("t1_c2", CB + 2, 0, 0, 1);

        // A = B = all 255, last host write shares its cycle with start, start re-pulsed at cycle 5
        for (int r = 0; r < 5; r++) hw(r, 255, 255, 255, 0);
        hw(5, 255, 255, 255, 1);
        chk("t2_drop_cleared", host_drop, 0);
        chk("t2_busy", busy, 1);
        wait_done(1, 5, cyc);
        chk("t2_done_cycle", cyc, 22);
        chk("t2_model_acc", exp_c[1][1], 195075);
        tick;
        chk("t2_done_single", done, 0);
        chk("t2_idle", busy, 0);
        repeat (3) tick;
        chk("t2_no_restart", busy, 0);
        for (int r = 0; r < 3; r++) chk_row("t2_c", CB + r, C_ALL, C_ALL, C_ALL);

        // Reset during row 1 ACC abandons the run but keeps row 0 of C
        hw(0, 2, 0, 0, 0); hw(1, 0, 3, 0, 0); hw(2, 0, 0, 4, 0);
        hw(3, 1, 0, 0, 0); hw(4, 0, 1, 0, 0); hw(5, 0, 0, 1, 0);
        start = 1; tick; start = 0;
        cyc = 1;
        while (cyc < 9) begin
            host_we = cyc == 3;
            tick;
            host_we = 0;
            cyc++;
        end
        chk("t3_drop_before_rst", host_drop, 1);
        rst_n = 0;
        #1;
        chk("t3_busy", busy, 0);
        chk("t3_done", done, 0);
        chk("t3_en_read", rf_en_read, 0);
        chk("t3_en_write", rf_en_write, 0);
        chk("t3_drop", host_drop, 0);
        chk("t3_waddr", rf_waddr1, 0);
        chk("t3_wdata", rf_wdata1, 0);
        chk("t3_raddr", rf_raddr1, 0);
        tick;
        chk_row("t3_c0_kept", CB, 2, 0, 0);
        chk_row("t3_c1_old", CB + 1, C_ALL, C_ALL, C_ALL);
        rst_n = 1;
        tick;
        start = 1; tick; start = 0;
        wait_done(1, -1, cyc);
        chk("t3_done_cycle", cyc, 22);
        tick;
        chk_row("t3_c1", CB + 1, 0, 3, 0);
        chk_row("t3_c2", CB + 2, 0, 0, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/simd_mm_seq.md
SIMD_MM_SEQ -- requirements
Module: simd_mm_seq

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter DW, default 8: element width in bits.
REQ-003 Parameter AW, default 4: register-file address width.
REQ-004 Parameters A_BASE, B_BASE, C_BASE, defaults 0, 3, 6: row-0 addresses of matrices A, B and C.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  single-cycle request to run C = A x B.
REQ-008 busy  out  1  high while the sequence runs.
REQ-009 done  out  1  one-cycle completion pulse.
REQ-010 host_we / host_waddr / host_wdata0..2  in  1 / AW / DW each  host row write (three banks).
REQ-011 host_ready  out  1  high when a host write is accepted (sequencer idle).
REQ-012 host_drop  out  1  sticky flag: a host write arrived while busy.
REQ-013 rf_en_write / rf_waddr1..3 / rf_wdata1..3  out  1 / AW each / DW each  register-file write port.
REQ-014 rf_en_read / rf_raddr1..6  out  1 / AW each  register-file read port.
REQ-015 rf_rdata1..6  in  DW each  read data, valid one cycle after rf_en_read.

Function
REQ-016 Register-file row layout:
- Each row address holds three elements, one per bank.
- Read ports 1-3 read banks 0-2 at one address; ports 4-6 read banks 0-2 at a second address.
REQ-017 FSM states SHALL be IDLE, ISSUE, ACC, WRITE, DONE.
REQ-018 IDLE: start=1 goes to ISSUE and sets i=0, k=0, clears acc0..2; start=0 stays in IDLE.
REQ-019 ISSUE: rf_en_read=1, rf_raddr1..3=A_BASE+i, rf_raddr4..6=B_BASE+k; next state ACC.
REQ-020 ACC: for j=0..2, accj += A[i][k]*B[k][j], where A[i][k] is read port k+1 and B[k][j] is port j+4.
REQ-021 ACC exit: k<2 increments k and goes to ISSUE; k=2 goes to WRITE.
REQ-022 WRITE: rf_en_write=1, rf_waddr1..3=C_BASE+i, rf_wdataj=conv(accj); next state ISSUE with i+1, k=0 and accumulators cleared, or DONE if i=2.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE.
REQ-024 Latency:
- 7 cycles per row.
- done is asserted in the 22nd cycle after start is sampled.
- busy=1 in all states except IDLE.
REQ-025 Arithmetic:
- Operands unsigned.
- Products 2*DW bits; accumulators 2*DW+2 bits (no overflow is possible).
REQ-026 conv() SHALL be per REQ-034/REQ-035.
REQ-027 Host arbitration:
- In IDLE, host_we forwards host_waddr/host_wdata to the rf_* write port combinationally.
- host_ready=(state==IDLE).
REQ-028 Host writes while busy:
- host_we=1 while busy is dropped and sets host_drop.
- host_drop clears only on start accepted or on reset.
REQ-029 start while busy SHALL be ignored (no restart, no queueing).
REQ-030 Same-cycle start and host_we in IDLE: the host write completes and start is accepted.
REQ-031 rf_en_read and rf_en_write SHALL never be high in the same cycle.

Reset
REQ-032 rst_n=0 SHALL immediately force:
- state IDLE
- busy, done, rf_en_read, rf_en_write and host_drop at 0
- all addresses, write data, accumulators, i and k at 0
REQ-033 Reset mid-run SHALL abandon the sequence; C rows already written remain in the register file.

Configuration
REQ-034 With SIMD_MM_SAT_EN defined, conv(acc) SHALL saturate to 2^DW-1 when acc exceeds it.
REQ-035 Without SIMD_MM_SAT_EN, conv(acc) SHALL be acc[DW-1:0] (truncation).

Structure
REQ-036 Package simd_pkg SHALL hold:
- the state enum
- DW/AW defaults
- A_BASE/B_BASE/C_BASE defaults
- accumulator-width constant
REQ-037 One sub-module, simd_mac3, SHALL hold the three DW x DW multipliers and accumulators (clear/enable inputs).

Verification
REQ-038 A=[1,2,3;0,1,0;0,0,1], B=identity; start -> C rows 1,2,3 / 0,1,0 / 0,0,1 written at addresses 6-8, done 22 cycles after start.
REQ-039 A=B=all 255 -> each acc=195075; SAT_EN gives every C element 255; without SAT_EN every C element is 3 (195075 mod 256).
REQ-040 host_we pulsed during ISSUE -> no rf write that cycle, host_drop=1, C still correct.
REQ-041 start re-pulsed at cycle 5 of a run -> single done pulse, at cycle 22.
REQ-042 rst_n low during row 1 ACC -> all outputs 0 at once; row 0 of C retained; a new start completes normally.
REQ-043 Bench SHALL assert rf_en_read & rf_en_write never overlap and done width is 1 cycle.
